// File: rtl/xoodyak_input_loader_pkg.sv
// Shared types and frame-layout constants for the xoodyak input loader.
package xood_loader_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } ld_state_t;

  localparam int unsigned ENC_WORDS = 18;
  localparam int unsigned DEC_WORDS = 22;

  localparam int unsigned KEY_B   = 0;
  localparam int unsigned NONCE_B = 4;
  localparam int unsigned AD_B    = 8;
  localparam int unsigned TEXT_B  = 12;
  localparam int unsigned TAG_B   = 18;

  // Index of the final word of a frame for the given operating mode.
  function automatic logic [4:0] last_idx(input logic dec);
    logic [4:0] r;
    if (dec) begin
      r = 5'(DEC_WORDS - 1);
    end else begin
      r = 5'(ENC_WORDS - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/xoodyak_input_loader_if.sv
// Word-stream handshake between an upstream producer and the xoodyak input loader.
interface xoodyak_input_loader_if #(
  parameter int W = 32
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_sof;
  logic         in_opmode;
  logic         in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_sof,
    output in_opmode,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sof,
    input  in_opmode,
    output in_ready
  );
endinterface

// File: rtl/xoodyak_input_loader_demux.sv
// Decodes a frame word index into one field write enable and the 32-bit lane within that field.
module xood_word_demux
  import xood_loader_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic       o_we_key,
  output logic       o_we_nonce,
  output logic       o_we_ad,
  output logic       o_we_text,
  output logic       o_we_tag,
  output logic [2:0] o_lane
);

  logic [4:0] w_off;

  // Field select by index range; indices past the tag field select nothing.
  always_comb begin
    o_we_key   = 1'b0;
    o_we_nonce = 1'b0;
    o_we_ad    = 1'b0;
    o_we_text  = 1'b0;
    o_we_tag   = 1'b0;
    w_off      = 5'd0;
    if (i_idx < 5'(NONCE_B)) begin
      o_we_key = 1'b1;
      w_off    = i_idx - 5'(KEY_B);
    end else if (i_idx < 5'(AD_B)) begin
      o_we_nonce = 1'b1;
      w_off      = i_idx - 5'(NONCE_B);
    end else if (i_idx < 5'(TEXT_B)) begin
      o_we_ad = 1'b1;
      w_off   = i_idx - 5'(AD_B);
    end else if (i_idx < 5'(TAG_B)) begin
      o_we_text = 1'b1;
      w_off     = i_idx - 5'(TEXT_B);
    end else if (i_idx < 5'(DEC_WORDS)) begin
      o_we_tag = 1'b1;
      w_off    = i_idx - 5'(TAG_B);
    end else begin
      w_off = 5'd0;
    end
    o_lane = w_off[2:0];
  end

endmodule

// File: rtl/xoodyak_input_loader.sv
// Assembles xoodyak core operands from a 32-bit word stream and launches the core.
// Optional: define XOOD_LOADER_ZEROIZE_EN to clear key/textin/tag when the core finishes.
module xoodyak_input_loader
  import xood_loader_pkg::*;
#(
  parameter int W      = 32,
  parameter int DATA_W = 128,
  parameter int TEXT_W = 192
) (
  input  logic                eph1,
  input  logic                reset_n,
  xoodyak_input_loader_if.slave s_in,
  output logic [DATA_W-1:0]   key,
  output logic [DATA_W-1:0]   nonce,
  output logic [DATA_W-1:0]   assodata,
  output logic [TEXT_W-1:0]   textin,
  output logic [DATA_W-1:0]   verification_data,
  output logic                opmode,
  output logic                start,
  input  logic                sqzdone,
  output logic                busy
);

  if (W != 32) begin : g_bad_width
    $error("xoodyak_input_loader: only W = 32 is supported");
  end

  ld_state_t         r_state;
  logic [4:0]        r_cnt;
  logic              r_in_ready;
  logic              r_start;
  logic              r_busy;
  logic              r_opmode;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] r_nonce;
  logic [DATA_W-1:0] r_ad;
  logic [TEXT_W-1:0] r_text;
  logic [DATA_W-1:0] r_tag;

  logic       w_accept;
  logic       w_write;
  logic       w_last;
  logic [4:0] w_idx;
  logic [W-1:0] w_word;
  logic       w_we_key;
  logic       w_we_nonce;
  logic       w_we_ad;
  logic       w_we_text;
  logic       w_we_tag;
  logic [2:0] w_lane;

  // in_ready is only ever high in LOAD, so acceptance implies LOAD.
  assign w_accept = s_in.in_valid & r_in_ready;
  assign w_idx    = s_in.in_sof ? 5'd0 : r_cnt;
  assign w_write  = w_accept & (s_in.in_sof | (r_cnt != 5'd0));
  assign w_last   = w_write & (w_idx == last_idx(r_opmode));
  assign w_word   = s_in.in_data;

  xood_word_demux u_demux (
    .i_idx      (w_idx),
    .o_we_key   (w_we_key),
    .o_we_nonce (w_we_nonce),
    .o_we_ad    (w_we_ad),
    .o_we_text  (w_we_text),
    .o_we_tag   (w_we_tag),
    .o_lane     (w_lane)
  );

  // Frame sequencing: word counter, handshake and core launch/busy flags.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LOAD;
      r_cnt      <= 5'd0;
      r_in_ready <= 1'b0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_in_ready <= 1'b1;
          r_start    <= 1'b0;
          r_busy     <= 1'b0;
          if (w_last) begin
            r_state    <= START;
            r_cnt      <= 5'd0;
            r_in_ready <= 1'b0;
            r_start    <= 1'b1;
            r_busy     <= 1'b1;
          end else if (w_write) begin
            r_cnt <= w_idx + 5'd1;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        START: begin
          r_state <= BUSY;
          r_start <= 1'b0;
          r_busy  <= 1'b1;
        end
        BUSY: begin
          if (sqzdone) begin
            r_state    <= LOAD;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state    <= LOAD;
          r_cnt      <= 5'd0;
          r_in_ready <= 1'b0;
          r_start    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers: written only while loading, so they hold through START/BUSY.
  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_opmode <= 1'b0;
      r_key    <= '0;
      r_nonce  <= '0;
      r_ad     <= '0;
      r_text   <= '0;
      r_tag    <= '0;
    end else if (w_write) begin
      if (s_in.in_sof) begin
        r_opmode <= s_in.in_opmode;
      end else begin
        r_opmode <= r_opmode;
      end
      for (int j = 0; j < 4; j++) begin
        if (w_lane == 3'(j)) begin
          if (w_we_key)   r_key[32*j +: 32]   <= w_word;
          if (w_we_nonce) r_nonce[32*j +: 32] <= w_word;
          if (w_we_ad)    r_ad[32*j +: 32]    <= w_word;
          if (w_we_tag)   r_tag[32*j +: 32]   <= w_word;
        end
      end
      for (int j = 0; j < 6; j++) begin
        if (w_we_text && (w_lane == 3'(j))) begin
          r_text[32*j +: 32] <= w_word;
        end
      end
    end
`ifdef XOOD_LOADER_ZEROIZE_EN
    else if ((r_state == BUSY) && sqzdone) begin
      r_key  <= '0;
      r_text <= '0;
      r_tag  <= '0;
    end
`endif
    else begin
      r_opmode <= r_opmode;
    end
  end

  assign s_in.in_ready     = r_in_ready;
  assign key               = r_key;
  assign nonce             = r_nonce;
  assign assodata          = r_ad;
  assign textin            = r_text;
  assign verification_data = r_tag;
  assign opmode            = r_opmode;
  assign start             = r_start;
  assign busy              = r_busy;

endmodule

// File: doc/xoodyak_input_loader.md
Name: xoodyak_input_loader

Overview:
- Upstream feeder for the xoodyak core.
- Accepts a 32-bit word stream over a valid/ready handshake and assembles the core's wide operands: key, nonce, assodata, textin, and, when decrypting, verification_data.
- Once a frame is complete it issues a one-cycle start pulse to the core.
- It then holds all operands stable until the core reports sqzdone.

Parameters:
- W, 32, stream word width. Only 32 is supported; any other value is flagged by an elaboration-time assertion.
- DATA_W, 128, width of key, nonce, assodata and verification_data.
- TEXT_W, 192, width of textin.

Ports:
- eph1  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  W  stream word.
- in_valid  input  1  in_data is valid.
- in_sof  input  1  first word of a frame; qualified by in_valid.
- in_opmode  input  1  0 = encrypt, 1 = decrypt; sampled with the sof word.
- in_ready  output  1  loader accepts a word this cycle.
- key  output  DATA_W  to core.
- nonce  output  DATA_W  to core.
- assodata  output  DATA_W  to core.
- textin  output  TEXT_W  to core.
- verification_data  output  DATA_W  to core; tag to be checked on decrypt.
- opmode  output  1  to core.
- start  output  1  one-cycle pulse to core.
- sqzdone  input  1  core finished squeezing.
- busy  output  1  high in states START and BUSY.

Behaviour:
- Handshake: a word is accepted when in_valid & in_ready at a rising edge of eph1.
- Frame order, word index n:
  - key: n = 0..3
  - nonce: n = 4..7
  - assodata: n = 8..11
  - textin: n = 12..17
  - verification_data: n = 18..21, decrypt only
- Within each field, word j fills bits [32j+31:32j], so the least-significant word comes first.
- Frame length is 18 words for encrypt and 22 words for decrypt.
- States: LOAD, START, BUSY. The 5-bit word counter cnt is reset to 0.
- LOAD:
  - in_ready = 1.
  - A word accepted with in_sof = 1 is always treated as n = 0: opmode is latched from in_opmode and cnt becomes 1. This resyncs a partial frame; previously written fields are not cleared.
  - A word accepted with in_sof = 0 while cnt == 0 is dropped, and cnt stays 0.
  - Otherwise the word is written to index cnt and cnt increments.
  - On acceptance of the last word (n = 17 for encrypt, n = 21 for decrypt): next state is START and cnt is cleared.
- START:
  - in_ready = 0, start = 1, busy = 1.
  - Exactly one cycle; next state is BUSY.
  - sqzdone is ignored in this state.
- BUSY:
  - in_ready = 0, start = 0, busy = 1.
  - When sqzdone = 1, next state is LOAD.
  - Operand outputs must not change in START or BUSY.
- Latency: start rises on the first edge after the last word is accepted. The first word of the next frame can be accepted on the edge after sqzdone is sampled.
- All outputs are registered.
- Reset, asynchronous and including mid-frame or mid-BUSY:
  - state = LOAD, cnt = 0.
  - All operand registers = 0, opmode = 0.
  - start = 0, busy = 0.
  - in_ready = 0 while reset_n = 0; in_ready = 1 after reset_n deasserts.

Optional Feature:
- Macro: XOOD_LOADER_ZEROIZE_EN.
- Defined: on the edge where sqzdone is sampled in BUSY, the key, textin and verification_data registers clear to 0. nonce, assodata and opmode retain their values.
- Not defined: all operands retain their values until overwritten by the next frame.

Decomposition:
- Package xood_loader_pkg holds:
  - state enum ld_state_t {LOAD, START, BUSY}.
  - Constants ENC_WORDS = 18 and DEC_WORDS = 22.
  - Field base indices KEY_B = 0, NONCE_B = 4, AD_B = 8, TEXT_B = 12, TAG_B = 18.
- Sub-module xood_word_demux: combinational decode of cnt to per-field write enables and word-lane selects. The loader owns the state register and the operand registers.

Test Plan:
- Encrypt frame: 18 words, key words 0x34353637, 0x30313233, 0x3c3d3e3f, 0x38393a3b, in_opmode = 0.
  - key = 0x38393a3b3c3d3e3f3031323334353637.
  - start is high for exactly 1 cycle, on the edge after word 17 is accepted.
  - opmode = 0.
- Same frame with in_valid randomly low on about 50% of cycles, plus sqzdone driven 20 cycles after start.
  - Identical operands.
  - Outputs stable throughout BUSY.
  - in_ready returns to 1 on the cycle after sqzdone.
- Decrypt frame: 22 words with in_opmode = 1, tag words 0xA..0xD.
  - verification_data = 0x0000000D0000000C0000000B0000000A.
  - start only after the 22nd word.
- Resync: send 7 words, then a new sof frame of 18 words.
  - Exactly one start.
  - key/nonce come from the second frame.
  - A non-sof word sent while cnt = 0 is dropped.
- Drop reset_n mid-BUSY:
  - All outputs go to 0 asynchronously and in_ready = 0 during reset.
  - After release, in_ready = 1 and the next full frame starts normally.
- With XOOD_LOADER_ZEROIZE_EN defined:
  - After sqzdone, key = 0, textin = 0, verification_data = 0.
  - nonce and assodata are unchanged.
